// File: rtl/johnson_pkg.sv
// Shared types, constants and the Johnson word decoder
// for the Johnson-bus receive checker.
package johnson_pkg;

    localparam int JOHNSON_WIDTH  = 8;
    localparam int JOHNSON_PHASES = 2 * JOHNSON_WIDTH;

    typedef enum logic [1:0] {
        UNLOCK,
        ACQUIRE,
        LOCKED
    } lock_state_t;

    // Returns {legal, phase}; an unmatched word returns all zeros.
    function automatic logic [4:0] johnson_decode_fn(
        input logic [0:JOHNSON_WIDTH-1] w
    );
        logic [0:JOHNSON_WIDTH-1] pat;
        logic [4:0]               res;
        res = '0;
        for (int k = 0; k < JOHNSON_PHASES; k++) begin
            for (int i = 0; i < JOHNSON_WIDTH; i++) begin
                if (k <= JOHNSON_WIDTH)
                    pat[i] = (i < k);
                else
                    pat[i] = (i >= k - JOHNSON_WIDTH);
            end
            if (w == pat)
                res = {1'b1, 4'(k)};
        end
        return res;
    endfunction

endpackage

// File: rtl/johnson_rx_checker_decode.sv
// Combinational decode of one Johnson word
// into a legal flag and a phase index.
module johnson_decode
    import johnson_pkg::*;
(
    input  logic [0:JOHNSON_WIDTH-1] word,
    output logic                     legal,
    output logic [3:0]               phase
);

    always_comb begin
        {legal, phase} = johnson_decode_fn(word);
    end

endmodule

// File: rtl/johnson_rx_checker.sv
// Johnson-bus receive checker: phase decode, step check,
// lock state machine and saturating error counter.
module johnson_rx_checker
    import johnson_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int PH_W        = 4,
    parameter int LOCK_CNT    = 4,
    parameter int UNLOCK_ERRS = 2,
    parameter int ERR_W       = 8,
    parameter int ALLOW_HOLD  = 1
) (
    input  logic             clk,
    input  logic             r,
    input  logic             sample_en,
    input  logic [0:WIDTH-1] johnson_in,
    input  logic             err_clr,
    output logic [PH_W-1:0]  phase_out,
    output logic             phase_valid,
    output logic             code_err,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    localparam int GC_W = $clog2(LOCK_CNT + 1);
    localparam int BC_W = $clog2(UNLOCK_ERRS + 1);

    logic [0:WIDTH-1] s_word;
    logic             s_vld;
    logic             d_legal;
    logic [PH_W-1:0]  d_phase;

    logic [PH_W-1:0]  prev_phase;
    logic [PH_W-1:0]  nxt_phase;
    logic             prev_valid;

    lock_state_t      state, state_n;
    logic [GC_W-1:0]  good_cnt, good_n, good_inc;
    logic [BC_W-1:0]  bad_cnt, bad_n, bad_inc;

    logic step_ok;
    logic c_err;
    logic q_err;
    logic good;
    logic any_err;

    johnson_decode u_dec (
        .word  (s_word),
        .legal (d_legal),
        .phase (d_phase)
    );

    assign nxt_phase = prev_phase + 1'b1;
    assign good_inc  = good_cnt + 1'b1;
    assign bad_inc   = bad_cnt + 1'b1;

    always_comb begin
        step_ok = prev_valid &&
                  ((d_phase == nxt_phase) ||
                   ((ALLOW_HOLD != 0) && (d_phase == prev_phase)));
        c_err   = s_vld && !d_legal;
        q_err   = s_vld && d_legal && prev_valid && !step_ok;
        good    = s_vld && d_legal && step_ok;
        any_err = c_err || q_err;
    end

    // Lock state machine; only sampled cycles move it.
    always_comb begin
        state_n = state;
        good_n  = good_cnt;
        bad_n   = bad_cnt;
        if (s_vld) begin
            unique case (state)
                UNLOCK: begin
                    if (d_legal) begin
                        state_n = ACQUIRE;
                        good_n  = '0;
                    end
                end
                ACQUIRE: begin
                    if (any_err) begin
                        state_n = UNLOCK;
                    end else if (good) begin
                        if (good_inc == GC_W'(LOCK_CNT)) begin
                            state_n = LOCKED;
                            bad_n   = '0;
                        end else begin
                            good_n = good_inc;
                        end
                    end
                end
                LOCKED: begin
                    if (good) begin
                        bad_n = '0;
                    end else if (bad_inc == BC_W'(UNLOCK_ERRS)) begin
                        state_n = UNLOCK;
                    end else begin
                        bad_n = bad_inc;
                    end
                end
                default: state_n = UNLOCK;
            endcase
        end
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            s_word      <= '0;
            s_vld       <= 1'b0;
            phase_out   <= '0;
            phase_valid <= 1'b0;
            code_err    <= 1'b0;
            seq_err     <= 1'b0;
            prev_phase  <= '0;
            prev_valid  <= 1'b0;
            state       <= UNLOCK;
            good_cnt    <= '0;
            bad_cnt     <= '0;
            err_count   <= '0;
        end else begin
            s_vld <= sample_en;
            if (sample_en)
                s_word <= johnson_in;
            phase_valid <= s_vld && d_legal;
            code_err    <= c_err;
            seq_err     <= q_err;
            if (s_vld && d_legal) begin
                phase_out  <= d_phase;
                prev_phase <= d_phase;
                prev_valid <= 1'b1;
            end else if (c_err) begin
                prev_valid <= 1'b0;
            end
            state    <= state_n;
            good_cnt <= good_n;
            bad_cnt  <= bad_n;
            // A clear with a same-cycle error leaves a count of one.
            if (err_clr)
                err_count <= any_err ? ERR_W'(1) : '0;
            else if (any_err && (err_count != '1))
                err_count <= err_count + ERR_W'(1);
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_johnson_rx_checker.sv
// Randomized and directed checks of johnson_rx_checker against
// a behavioural model, for hold-allowed and hold-forbidden builds.
module tb_johnson_rx_checker;

    logic       clk = 1'b0;
    logic       r = 1'b1;
    logic       sample_en = 1'b0;
    logic [7:0] word = 8'h00;
    logic       err_clr = 1'b0;

    logic [3:0] ph_h, ph_n;
    logic       pv_h, pv_n, ce_h, ce_n, se_h, se_n, lk_h, lk_n;
    logic [7:0] ec_h, ec_n;

    int n_vec = 0;
    int n_chk = 0;
    int n_err = 0;

    johnson_rx_checker #(.ALLOW_HOLD(1)) dut_h (
        .clk(clk), .r(r), .sample_en(sample_en), .johnson_in(word),
        .err_clr(err_clr), .phase_out(ph_h), .phase_valid(pv_h),
        .code_err(ce_h), .seq_err(se_h), .locked(lk_h),
        .err_count(ec_h)
    );

    johnson_rx_checker #(.ALLOW_HOLD(0)) dut_n (
        .clk(clk), .r(r), .sample_en(sample_en), .johnson_in(word),
        .err_clr(err_clr), .phase_out(ph_n), .phase_valid(pv_n),
        .code_err(ce_n), .seq_err(se_n), .locked(lk_n),
        .err_count(ec_n)
    );

    always #5 clk = ~clk;

    // Model state; index 0 = hold allowed, 1 = hold forbidden.
    int  m_state[2], m_good[2], m_bad[2];
    int  m_prev[2], m_phase[2], m_cnt[2];
    bit  m_pvld[2], m_pv[2], m_ce[2], m_se[2];
    bit  m_svld;
    logic [7:0] m_sword;

    // Word value: MSB is the head bit.
    function automatic logic [7:0] gen(input int k);
        logic [7:0] t;
        t = 8'hFF;
        if (k <= 8)
            t = t << (8 - k);
        else
            t = t >> (k - 8);
        return t;
    endfunction

    function automatic void ref_decode(input logic [7:0] w,
                                       output bit legal,
                                       output int k);
        int ones;
        logic [7:0] t;
        ones  = $countones(w);
        legal = 0;
        k     = 0;
        t     = 8'hFF;
        if (ones == 0) begin
            legal = 1;
        end else if (w[7]) begin
            t = t << (8 - ones);
            if (w == t) begin
                legal = 1;
                k = ones;
            end
        end else begin
            t = t >> (8 - ones);
            if (w == t) begin
                legal = 1;
                k = 16 - ones;
            end
        end
    endfunction

    function automatic logic [7:0] rand_illegal();
        logic [7:0] w;
        bit lg;
        int k;
        for (int i = 0; i < 100; i++) begin
            w = 8'($urandom);
            ref_decode(w, lg, k);
            if (!lg) return w;
        end
        return 8'b10100000;
    endfunction

    task automatic model_reset();
        for (int h = 0; h < 2; h++) begin
            m_state[h] = 0; m_good[h] = 0; m_bad[h] = 0;
            m_prev[h] = 0; m_phase[h] = 0; m_cnt[h] = 0;
            m_pvld[h] = 0; m_pv[h] = 0; m_ce[h] = 0; m_se[h] = 0;
        end
        m_svld  = 0;
        m_sword = 8'h00;
    endtask

    task automatic model_step(input bit clr);
        bit legal, hold, ok, err;
        int k;
        for (int h = 0; h < 2; h++) begin
            hold = (h == 0);
            m_pv[h] = 0; m_ce[h] = 0; m_se[h] = 0;
            ok = 0;
            if (m_svld) begin
                ref_decode(m_sword, legal, k);
                if (legal) begin
                    ok = m_pvld[h] &&
                         (k == (m_prev[h] + 1) % 16 ||
                          (hold && k == m_prev[h]));
                    m_se[h]    = m_pvld[h] && !ok;
                    m_pv[h]    = 1;
                    m_phase[h] = k;
                    m_prev[h]  = k;
                    m_pvld[h]  = 1;
                end else begin
                    m_ce[h]   = 1;
                    m_pvld[h] = 0;
                end
                case (m_state[h])
                    0: if (legal) begin
                        m_state[h] = 1;
                        m_good[h]  = 0;
                    end
                    1: if (m_ce[h] || m_se[h]) begin
                        m_state[h] = 0;
                    end else if (ok) begin
                        m_good[h]++;
                        if (m_good[h] == 4) begin
                            m_state[h] = 2;
                            m_bad[h]   = 0;
                        end
                    end
                    default: if (ok) begin
                        m_bad[h] = 0;
                    end else begin
                        m_bad[h]++;
                        if (m_bad[h] == 2) m_state[h] = 0;
                    end
                endcase
            end
            err = m_ce[h] || m_se[h];
            if (clr)
                m_cnt[h] = err ? 1 : 0;
            else if (err && m_cnt[h] < 255)
                m_cnt[h]++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t",
                   tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("h.phase_out",   32'(ph_h), 32'(m_phase[0]));
        check("h.phase_valid", 32'(pv_h), 32'(m_pv[0]));
        check("h.code_err",    32'(ce_h), 32'(m_ce[0]));
        check("h.seq_err",     32'(se_h), 32'(m_se[0]));
        check("h.locked",      32'(lk_h), 32'(m_state[0] == 2));
        check("h.err_count",   32'(ec_h), 32'(m_cnt[0]));
        check("n.phase_out",   32'(ph_n), 32'(m_phase[1]));
        check("n.phase_valid", 32'(pv_n), 32'(m_pv[1]));
        check("n.code_err",    32'(ce_n), 32'(m_ce[1]));
        check("n.seq_err",     32'(se_n), 32'(m_se[1]));
        check("n.locked",      32'(lk_n), 32'(m_state[1] == 2));
        check("n.err_count",   32'(ec_n), 32'(m_cnt[1]));
    endtask

    task automatic tick(input bit en, input logic [7:0] w,
                        input bit clr);
        sample_en = en;
        word      = w;
        err_clr   = clr;
        @(posedge clk);
        model_step(clr);
        m_svld = en;
        if (en) m_sword = w;
        #1;
        n_vec++;
        check_all();
    endtask

    initial begin
        int cur, sel;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        r = 1'b0;

        // Full rotation, then one idle cycle to see the last result.
        for (int k = 0; k <= 16; k++) begin
            tick(1, gen(k % 16), 0);
            if (k == 4) check("lock_after_5th", 32'(lk_h), 32'(0));
            if (k == 5) check("lock_at_5th", 32'(lk_h), 32'(1));
        end
        tick(0, 8'h00, 0);
        check("rot.phase_out", 32'(ph_h), 32'(0));
        check("rot.err_count", 32'(ec_h), 32'(0));

        // Illegal code while locked, then a restart sample.
        tick(1, 8'b10100000, 0);
        tick(1, 8'b00000000, 0);
        check("ill.code_err", 32'(ce_h), 32'(1));
        check("ill.locked", 32'(lk_h), 32'(1));
        check("ill.err_count", 32'(ec_h), 32'(1));
        tick(0, 8'h00, 0);
        check("ill.unlock", 32'(lk_h), 32'(0));

        // Skipped phases.
        tick(1, gen(3), 0);
        tick(1, gen(6), 0);
        tick(1, gen(7), 0);
        check("skip.seq_err", 32'(se_h), 32'(1));
        check("skip.phase", 32'(ph_h), 32'(6));
        tick(0, 8'h00, 0);
        check("skip.recover", 32'(se_h), 32'(0));

        // Holding one phase.
        tick(1, gen(1), 0);
        tick(1, gen(2), 0);
        tick(1, gen(2), 0);
        tick(1, gen(2), 0);
        check("hold.h_seq", 32'(se_h), 32'(0));
        check("hold.n_seq", 32'(se_n), 32'(1));
        tick(0, 8'h00, 0);
        check("hold.phase", 32'(ph_h), 32'(2));

        // Saturation and clear-with-error.
        for (int i = 0; i < 300; i++) tick(1, rand_illegal(), 0);
        check("sat.err_count", 32'(ec_h), 32'(255));
        tick(1, rand_illegal(), 1);
        check("clr.err_count", 32'(ec_h), 32'(1));
        tick(0, 8'h00, 0);
        tick(0, 8'h00, 1);
        check("clr.zero", 32'(ec_h), 32'(0));

        // Random walk.
        cur = 0;
        for (int i = 0; i < 250; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 4 || sel == 9) begin
                cur = (cur + 1) % 16;
                tick(1, gen(cur), ($urandom_range(0, 15) == 0));
            end else if (sel == 5) begin
                tick(1, gen(cur), ($urandom_range(0, 15) == 0));
            end else if (sel == 6) begin
                cur = $urandom_range(0, 15);
                tick(1, gen(cur), ($urandom_range(0, 15) == 0));
            end else if (sel == 7) begin
                tick(1, rand_illegal(), ($urandom_range(0, 15) == 0));
            end else begin
                tick(0, 8'($urandom), ($urandom_range(0, 15) == 0));
            end
        end

        // Lock, then asynchronous reset between edges.
        for (int k = 0; k < 8; k++) tick(1, gen(k), 0);
        tick(1, 8'b10100000, 0);
        tick(1, 8'b10100000, 0);
        check("pre_rst.locked", 32'(lk_h), 32'(1));
        #2;
        r = 1'b1;
        #1;
        model_reset();
        check_all();
        check("rst.locked", 32'(lk_h), 32'(0));
        check("rst.err_count", 32'(ec_h), 32'(0));
        check("rst.phase_out", 32'(ph_h), 32'(0));
        @(negedge clk);
        r = 1'b0;
        tick(1, gen(5), 0);
        tick(1, gen(6), 0);
        check("post_rst.seq", 32'(se_h), 32'(0));
        check("post_rst.pv", 32'(pv_h), 32'(1));
        tick(0, 8'h00, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
